// File: rtl/tff_counter_pkg.sv
// Shared constants and helpers for tff_counter: saturate-mode encodings, load clamp, terminal value.
// Pure combinational helpers; no latency, no backpressure.
package tff_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Loads beyond the count range land on the top of the range.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modv);
    return (val >= modv) ? modv - 32'd1 : val;
  endfunction

  // Value at which the counter sits at the end of its range for the given direction.
  function automatic int unsigned term_val(input logic up, input int unsigned modv);
    return up ? modv - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/tff_counter_cell.sv
// 1-bit toggle flip-flop with synchronous reset to a per-bit value and synchronous load.
// One cycle from rst/ld/t to q; no backpressure.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= rst_val;
    else if (ld)
      q <= d;
    else
      q <= q ^ t;
  end

endmodule

// File: rtl/tff_counter.sv
// Modulo up/down counter built from toggle cells; wrap or saturate, tc and ovf pulse.
// One cycle from rst/load/en to q; no backpressure. Sticky overflow via TFF_COUNTER_OVF_STICKY_EN.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MOD      = 16,
  parameter int unsigned RST_VAL  = 0,
  parameter int          SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf,
  output logic             ovf_sticky
);

  // One extra bit keeps MOD-1 representable and comparisons exact when MOD = 2^WIDTH.
  localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MOD - 32'd1);
  localparam logic [WIDTH:0]   ONE    = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RST_VAL);

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   nxt_x;
  logic [WIDTH-1:0] ld_q;
  logic [WIDTH-1:0] toggle;
  logic             wrap;
  logic             ovf_nxt;
  logic             unused_nxt_msb;

  assign q_x            = {1'b0, q};
  assign ld_q           = WIDTH'(clamp_load(32'(load_val), MOD));
  assign qbar           = ~q;
  assign tc             = (q_x == (WIDTH+1)'(term_val(up, MOD)));
  assign unused_nxt_msb = nxt_x[WIDTH];

  always_comb begin
    nxt_x = q_x;
    wrap  = 1'b0;
    if (en) begin
      if (up) begin
        if (q_x == MOD_M1) begin
          wrap  = 1'b1;
          nxt_x = (SATURATE == MODE_SAT) ? q_x : '0;
        end else begin
          nxt_x = q_x + ONE;
        end
      end else begin
        if (q_x == '0) begin
          wrap  = 1'b1;
          nxt_x = (SATURATE == MODE_SAT) ? q_x : MOD_M1;
        end else begin
          nxt_x = q_x - ONE;
        end
      end
    end
    // Cells only need to know which bits flip; load and reset bypass the toggle path.
    toggle  = nxt_x[WIDTH-1:0] ^ q;
    ovf_nxt = wrap & ~load;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_Q[i]),
      .ld      (load),
      .d       (ld_q[i]),
      .t       (toggle[i]),
      .q       (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else
      ovf <= ovf_nxt;
  end

`ifdef TFF_COUNTER_OVF_STICKY_EN
  // A new overflow outranks a clear arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (ovf_nxt)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: a wrapping (RST_VAL=0) and a saturating (RST_VAL=3) MOD-10 instance
// driven by shared inputs, checked every cycle against an arithmetic model plus literal directed checks.
module tb_tff_counter;

  localparam int W  = 4;
  localparam int MD = 10;

  logic         clk = 1'b0;
  logic         rst, en, up, load, ovf_clr;
  logic [W-1:0] load_val;

  logic [W-1:0] q_w, qbar_w, q_s, qbar_s;
  logic         tc_w, ovf_w, st_w, tc_s, ovf_s, st_s;

  int n_cmp = 0;
  int n_bad = 0;

  // model state per instance: 0 = wrap, 1 = saturate
  int m_q [2];
  int m_ovf [2];
  int m_st [2];
  int rv [2] = '{0, 3};
  int sat [2] = '{0, 1};
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(W), .MOD(MD), .RST_VAL(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_w), .qbar(qbar_w), .tc(tc_w), .ovf(ovf_w), .ovf_sticky(st_w)
  );

  tff_counter #(.WIDTH(W), .MOD(MD), .RST_VAL(3), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_s), .qbar(qbar_s), .tc(tc_s), .ovf(ovf_s), .ovf_sticky(st_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: count as an integer, detect leaving 0..MD-1, then wrap or hold.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n;
      if (rst) begin
        m_q[i] = rv[i]; m_ovf[i] = 0; m_st[i] = 0;
      end else begin
        m_ovf[i] = 0;
        if (load) begin
          m_q[i] = (int'(load_val) >= MD) ? MD - 1 : int'(load_val);
        end else if (en) begin
          n = up ? m_q[i] + 1 : m_q[i] - 1;
          if (n < 0 || n >= MD) begin
            m_ovf[i] = 1;
            n = sat[i] ? m_q[i] : (n + MD) % MD;
          end
          m_q[i] = n;
        end
`ifdef TFF_COUNTER_OVF_STICKY_EN
        if (m_ovf[i] == 1) m_st[i] = 1;
        else if (ovf_clr) m_st[i] = 0;
`endif
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("w.q",    int'(q_w),    m_q[0]);
      chk("w.qbar", int'(qbar_w), (~m_q[0]) & 15);
      chk("w.tc",   int'(tc_w),   int'(up ? (m_q[0] == MD - 1) : (m_q[0] == 0)));
      chk("w.ovf",  int'(ovf_w),  m_ovf[0]);
      chk("w.st",   int'(st_w),   m_st[0]);
      chk("s.q",    int'(q_s),    m_q[1]);
      chk("s.qbar", int'(qbar_s), (~m_q[1]) & 15);
      chk("s.tc",   int'(tc_s),   int'(up ? (m_q[1] == MD - 1) : (m_q[1] == 0)));
      chk("s.ovf",  int'(ovf_s),  m_ovf[1]);
      chk("s.st",   int'(st_s),   m_st[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int up_seq [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; ovf_clr = 1'b0;
    step();
    chk("rst.w.q", int'(q_w), 0);
    chk("rst.s.q", int'(q_s), 3);
    chk("rst.w.ovf", int'(ovf_w), 0);

    // count up through a wrap
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k < 12; k++) begin
      step();
      chk("up.q", int'(q_w), up_seq[k]);
      chk("up.ovf", int'(ovf_w), (k == 10) ? 1 : 0);
      chk("up.tc", int'(tc_w), (up_seq[k] == 9) ? 1 : 0);
    end

    // count down from reset
    rst = 1'b1; step();
    rst = 1'b0; up = 1'b0; en = 1'b1; #1;
    chk("dn.tc0", int'(tc_w), 1);
    step();
    chk("dn.q9", int'(q_w), 9);
    chk("dn.ovf", int'(ovf_w), 1);
    step();
    chk("dn.q8", int'(q_w), 8);
    chk("dn.ovf0", int'(ovf_w), 0);

    // load beats enable, clamps above range
    up = 1'b1; load = 1'b1; load_val = 4'd7; step();
    chk("ld7.q", int'(q_w), 7);
    chk("ld7.ovf", int'(ovf_w), 0);
    load_val = 4'd12; step();
    chk("ld12.w.q", int'(q_w), 9);
    chk("ld12.s.q", int'(q_s), 9);

    // saturation from 8
    load_val = 4'd8; step();
    chk("sat.q8", int'(q_s), 8);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step(); chk("sat.q9a", int'(q_s), 9); chk("sat.ovf_a", int'(ovf_s), 0);
    step(); chk("sat.q9b", int'(q_s), 9); chk("sat.ovf_b", int'(ovf_s), 1);
    step(); chk("sat.q9c", int'(q_s), 9); chk("sat.ovf_c", int'(ovf_s), 1);
    en = 1'b0; step(); chk("sat.ovf_d", int'(ovf_s), 0);

    // reset outranks load and enable
    load = 1'b1; load_val = 4'd5; step();
    chk("rl.q5", int'(q_s), 5);
    rst = 1'b1; en = 1'b1; load_val = 4'd7; step();
    chk("rl.q", int'(q_s), 3);
    chk("rl.qbar", int'(qbar_s), 12);
    chk("rl.ovf", int'(ovf_s), 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

`ifdef TFF_COUNTER_OVF_STICKY_EN
    load = 1'b1; load_val = 4'd9; step();
    load = 1'b0; en = 1'b1; up = 1'b1; step();
    chk("st.wrap.q", int'(q_w), 0);
    chk("st.set", int'(st_w), 1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); chk("st.hold", int'(st_w), 1);
    end
    ovf_clr = 1'b1; step(); chk("st.clr", int'(st_w), 0);
    ovf_clr = 1'b0; load = 1'b1; load_val = 4'd9; step();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1; step();
    chk("st.setwins", int'(st_w), 1);
    ovf_clr = 1'b0; en = 1'b0;
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 4) != 0) ? (k[8] == 1'b0) : 1'($urandom_range(0, 1));
      ovf_clr  = ($urandom_range(0, 7) == 0);
      step();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
